apb_cmd_master: RTL and testbench
=================================

// Module: apb_cmd_master
// PURPOSE
//  Single-outstanding APB initiator. Turns a valid/ready command stream into APB setup/access transfers.
//  Returns read data, slave error and timeout status on a valid/ready response stream.
//  Drives the accelerator regfile (APB slave) from a test sequencer or host-side controller, on the same clock.
// PARAMETERS
//  ADDR_WIDTH      16   paddr / cmd address width (bits)
//  DATA_WIDTH      32   pwdata / prdata width (bits)
//  TIMEOUT_CYCLES  256  max ACCESS cycles waiting for pready before abort; 0 = timeout disabled
// PORTS
//  clk            in   1           core clock; all logic on posedge
//  reset_n        in   1           asynchronous, active-low reset
//  cmd_valid_i    in   1           command present
//  cmd_ready_o    out  1           command accepted when valid & ready at posedge
//  cmd_write_i    in   1           1 = write, 0 = read
//  cmd_addr_i     in   ADDR_WIDTH  target address
//  cmd_wdata_i    in   DATA_WIDTH  write data (ignored for reads)
//  rsp_valid_o    out  1           response present
//  rsp_ready_i    in   1           response consumed when valid & ready at posedge
//  rsp_rdata_o    out  DATA_WIDTH  read data (0 for writes, errors and timeouts)
//  rsp_err_o      out  1           pslverr seen, or timeout
//  rsp_timeout_o  out  1           transfer aborted by timeout
//  psel_o         out  1           APB select
//  penable_o      out  1           APB enable
//  pwrite_o       out  1           APB direction
//  paddr_o        out  ADDR_WIDTH  APB address
//  pwdata_o       out  DATA_WIDTH  APB write data
//  prdata_i       in   DATA_WIDTH  APB read data
//  pready_i       in   1           APB ready / wait-state
//  pslverr_i      in   1           APB slave error, sampled only with pready_i
// BEHAVIOUR
//  FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  Reset (async assert, any state): FSM = IDLE and every output = 0.
//   - This includes psel/penable, so a mid-transfer reset drops the bus immediately.
//   - Any pending response is lost.
//  IDLE:
//   - cmd_ready_o = 1; no other FSM state asserts it.
//   - On cmd_valid_i & cmd_ready_o: latch write/addr/wdata into pwrite_o/paddr_o/pwdata_o -> SETUP.
//  SETUP: psel_o = 1, penable_o = 0 for exactly one cycle -> ACCESS.
//  ACCESS:
//   - psel_o = 1, penable_o = 1; paddr/pwrite/pwdata stable from SETUP until the transfer ends.
//   - On pready_i = 1: capture rsp_rdata_o = (read & !pslverr_i) ? prdata_i : 0.
//     Capture rsp_err_o = pslverr_i and rsp_timeout_o = 0 -> RESP.
//   - The cycle after pready, psel_o and penable_o = 0 (no back-to-back transfers; min 1 idle bus cycle).
//  Timeout (TIMEOUT_CYCLES > 0):
//   - The counter clears on SETUP and increments each ACCESS cycle with pready_i = 0.
//   - When the count reaches TIMEOUT_CYCLES with pready still low, abort -> RESP with rdata = 0, err = 1, timeout = 1.
//   - psel/penable deassert on the next cycle.
//   - If pready_i arrives in the same cycle as the threshold, pready wins (normal completion).
//  RESP:
//   - rsp_valid_o = 1; response fields held stable until rsp_valid_o & rsp_ready_i, then -> IDLE.
//   - rsp_valid_o = 0 in every other state.
//  Latency: command accept at edge N -> SETUP cycle N+1 -> ACCESS N+2.
//   - Zero wait states: rsp_valid_o high in cycle N+3.
//   - Each wait state adds 1 cycle.
//   - Throughput: at most one transfer per 4 cycles with rsp_ready_i held at 1.
//  Response registers reset to 0 and hold their value after a handshake until the next capture.
//  No combinational path from any input to any output; all outputs are registered.
//  pslverr_i and prdata_i are ignored whenever pready_i = 0 or the FSM is not in ACCESS.
// TESTING
//  1. Write 0x4, data 0x0000_0010, pready tied 1:
//     SETUP at N+1, ACCESS at N+2, rsp_valid at N+3 with err = 0 and rdata = 0.
//  2. Read 0x8, slave returns 0xDEAD_BEEF after 3 wait states:
//     penable high for 4 cycles; rsp_rdata = 0xDEADBEEF, rsp_valid at N+6.
//  3. Read with pslverr = 1 alongside pready:
//     rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
//  4. TIMEOUT_CYCLES = 4, pready held 0:
//     abort after 4 ACCESS cycles; rsp_err = 1, rsp_timeout = 1; psel = 0 on the next cycle.
//  5. rsp_ready held 0 for 10 cycles with cmd_valid held 1:
//     cmd_ready stays 0 and the response stays stable; the second command is accepted 1 cycle after the response handshake.
//  6. reset_n pulsed low during ACCESS:
//     psel, penable and rsp_valid go 0 asynchronously; after release, a new command completes normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB initiator bridging a valid/ready command stream
// to APB transfers and returning status on a valid/ready response stream.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i                   command fields
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_timeout_o                 response fields
//   psel_o, penable_o, pwrite_o,
//   paddr_o, pwdata_o             APB request
//   prdata_i, pready_i, pslverr_i APB completion
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    // Counter only needs to reach TIMEOUT_CYCLES-1: the abort fires in the
    // ACCESS cycle whose wait would make the count equal the limit.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMAX =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            cmd_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Ready comes up one cycle after reset release.
                    cmd_ready_o <= 1'b1;
                    if (cmd_valid_i && cmd_ready_o) begin
                        pwrite_o    <= cmd_write_i;
                        paddr_o     <= cmd_addr_i;
                        pwdata_o    <= cmd_wdata_i;
                        psel_o      <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // pready has priority over a coincident timeout.
                    if (pready_i) begin
                        rsp_rdata_o   <= (!pwrite_o && !pslverr_i)
                                         ? prdata_i : '0;
                        rsp_err_o     <= pslverr_i;
                        rsp_timeout_o <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        state         <= RESP;
                    end else if (TO_EN && wait_cnt == TMAX) begin
                        rsp_rdata_o   <= '0;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rsp_valid_o   <= 1'b1;
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed cases plus randomized transfers
// against a transaction-level model of expected response and timing.
module tb_apb_cmd_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int n_cmp = 0;
    int n_bad = 0;

    apb_cmd_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .psel_o       (psel),
        .penable_o    (penable),
        .pwrite_o     (pwrite),
        .paddr_o      (paddr),
        .pwdata_o     (pwdata),
        .prdata_i     (prdata),
        .pready_i     (pready),
        .pslverr_i    (pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Bus activity that the master must ignore outside ACCESS.
    task automatic noise();
        pready  = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transfer: w = wait states before pready, e = slave error,
    // sd = slave read data, d = cycles rsp_ready is held low.
    task automatic txn(input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int w, input bit e,
                       input logic [DW-1:0] sd, input int d);
        logic [DW-1:0] x_rd;
        bit            x_err;
        bit            x_to;
        int            k;
        if (w >= TO) begin
            x_rd  = '0;
            x_err = 1'b1;
            x_to  = 1'b1;
        end else begin
            x_rd  = (!wr && !e) ? sd : '0;
            x_err = e;
            x_to  = 1'b0;
        end
        chk("idle_ready", cmd_ready, 1);
        chk("idle_psel", psel, 0);
        chk("idle_rspv", rsp_valid, 0);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        noise();
        step();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        chk("setup_psel", psel, 1);
        chk("setup_pen", penable, 0);
        chk("busy_ready", cmd_ready, 0);
        chk("paddr", paddr, a);
        chk("pwrite", pwrite, wr);
        chk("pwdata", pwdata, wd);
        noise();
        step();
        k = 0;
        forever begin
            chk("acc_psel", psel, 1);
            chk("acc_pen", penable, 1);
            chk("acc_paddr", paddr, a);
            chk("acc_pwdata", pwdata, wd);
            chk("acc_rspv", rsp_valid, 0);
            chk("acc_ready", cmd_ready, 0);
            if (k == w) begin
                pready  = 1'b1;
                prdata  = sd;
                pslverr = e;
            end else begin
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
            step();
            if (k == w || k == TO - 1) break;
            k++;
        end
        // Pending command must not be taken while a response waits.
        cmd_valid = 1'b1;
        for (int i = 0; i <= d; i++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, x_rd);
            chk("rsp_err", rsp_err, x_err);
            chk("rsp_to", rsp_timeout, x_to);
            chk("rsp_psel", psel, 0);
            chk("rsp_pen", penable, 0);
            chk("rsp_ready_blk", cmd_ready, 0);
            rsp_ready = (i == d);
            noise();
            step();
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("post_rspv", rsp_valid, 0);
        chk("post_ready", cmd_ready, 1);
        chk("post_psel", psel, 0);
        chk("post_hold", rsp_rdata, x_rd);
        chk("post_hold_err", rsp_err, x_err);
    endtask

    task automatic reset_in_access();
        chk("rst_pre_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0020;
        noise();
        step();
        cmd_valid = 1'b0;
        pready    = 1'b0;
        step();
        chk("rst_pre_pen", penable, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_pen", penable, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_paddr", paddr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", cmd_ready, 0);
        chk("reset_psel", psel, 0);
        chk("reset_pen", penable, 0);
        chk("reset_rspv", rsp_valid, 0);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_err", rsp_err, 0);
        chk("reset_to", rsp_timeout, 0);
        reset_n = 1'b1;
        step();

        txn(1'b1, 16'h0004, 32'h0000_0010, 0, 1'b0, 32'h1234_5678, 0);
        txn(1'b0, 16'h0008, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 0);
        reset_in_access();
        txn(1'b0, 16'h000C, 32'h0, 1, 1'b1, 32'hCAFE_F00D, 1);
        txn(1'b0, 16'h0010, 32'h0, 6, 1'b0, 32'h5555_AAAA, 0);
        txn(1'b1, 16'h0014, 32'hA5A5_0001, 2, 1'b0, 32'h0, 10);
        txn(1'b0, 16'h0018, 32'h0, TO - 1, 1'b0, 32'h0BAD_CAFE, 0);

        for (int n = 0; n < 60; n++) begin
            txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                int'($urandom_range(0, 5)),
                ($urandom_range(0, 3) == 0), $urandom,
                int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
